// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
//
// Purpose: FSM state encoding and the default operand width used by
//          serial_add and its bench.
// Ports:   none (package).
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/ha.sv
// rtl/ha.sv - half-adder cell
//
// Purpose: single-bit half adder.
// Ports:   a, b      - addend bits
//          sum       - a XOR b
//          carry     - a AND b
module ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_full_add.sv
// rtl/serial_add_full_add.sv - full adder built from two half adders
//
// Purpose: one-bit full adder; carry out is the OR of the two half-adder
//          carries (they can never both be 1).
// Ports:   a, b      - addend bits
//          ci        - carry in
//          s         - sum bit
//          co        - carry out
module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  ha u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  ha u_ha1 (
    .a     (s0),
    .b     (ci),
    .sum   (s),
    .carry (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_add.sv
// rtl/serial_add.sv - bit-serial adder stage, LSB first, one bit per clock
//
// Purpose: accepts a, b, cin on an input handshake, adds them one bit per
//          clock through a single full_add cell with a registered carry, and
//          presents sum/cout on an output handshake.
// Ports:   clk, rst_n          - clock, async active-low reset
//          in_valid/in_ready   - operand handshake (in_ready only in IDLE)
//          a, b, cin           - operands and carry in
//          out_valid/out_ready - result handshake (out_valid only in DONE)
//          sum, cout           - result register and carry register
//          ovf                 - signed overflow, only with SERIAL_ADD_OVF_EN
//          busy                - high while bits are being computed
// Config:  SERIAL_ADD_OVF_EN adds the ovf output and its register.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;
  logic last_bit;

  full_add u_full_add (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Operands shift right so bit 0 always feeds the adder; the result
        // fills from the MSB so after WIDTH steps bit 0 lands at position 0.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (last_bit) begin
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB, fa_co the carry out of it.
          ovf_d   = carry_q ^ fa_co;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign sum       = res_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add.sv
// tb/tb_serial_add.sv - self-checking bench for serial_add (WIDTH=8)
module tb_serial_add;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  vec_t sb[$];
  int   acc_cyc[$];
  vec_t vecs[7];

  serial_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endfunction

  function automatic vec_t mk(logic [W-1:0] va, logic [W-1:0] vb, logic vc);
    vec_t v;
    logic [W:0] full;
    full       = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
    v.a        = va;
    v.b        = vb;
    v.cin      = vc;
    v.exp_sum  = full[W-1:0];
    v.exp_cout = full[W];
    v.exp_ovf  = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
    return v;
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(mk(a, b, cin));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          check("sb_sum", 32'(sum), 32'(e.exp_sum));
          check("sb_cout", 32'(cout), 32'(e.exp_cout));
`ifdef SERIAL_ADD_OVF_EN
          check("sb_ovf", 32'(ovf), 32'(e.exp_ovf));
`endif
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, output int lat);
    int t0;
    int n;
    lat = -1;
    @(posedge clk); #1;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin check("accept_timeout", 32'd1, 32'd0); in_valid = 1'b0; return; end
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin check("result_timeout", 32'd1, 32'd0); return; end
    lat = cyc - t0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    logic [W-1:0] hold_sum;
    logic         hold_cout;

    vecs[0] = mk(8'h0F, 8'h01, 1'b0);
    vecs[1] = mk(8'hFF, 8'h01, 1'b0);
    vecs[2] = mk(8'hFF, 8'hFF, 1'b1);
    vecs[3] = mk(8'h7F, 8'h01, 1'b0);
    vecs[4] = mk(8'h12, 8'h34, 1'b0);
    vecs[5] = mk(8'h00, 8'h00, 1'b0);
    vecs[6] = mk(8'hAA, 8'h55, 1'b1);

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed spot checks against hand-computed values
    check("const_0F01_sum", 32'(vecs[0].exp_sum), 32'h10);

    // Table-driven vectors, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("latency_%0d", i), 32'(lat), 32'd9);
      if (i == 0) begin
        check("busy_in_done", 32'(busy), 32'd0);
        check("basic_sum", 32'(sum), 32'h10);
      end
      @(negedge clk);
      wait_idle();
    end

    // Backpressure: hold out_ready low 5 cycles, poke in_valid meanwhile
    out_ready = 1'b0;
    run_op(8'hFF, 8'h01, 1'b0, lat);
    hold_sum  = 8'h00;
    hold_cout = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      a = 8'h55; b = 8'h22; cin = 1'b1; in_valid = (k % 2 == 0);
      @(negedge clk);
      check("bp_sum", 32'(sum), 32'(hold_sum));
      check("bp_cout", 32'(cout), 32'(hold_cout));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back with in_valid and out_ready held high
    acc_cyc.delete();
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(out_valid) && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2)
      check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
    wait_idle();
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of SHIFT, at bit 4
    @(posedge clk); #1;
    a = 8'hC3; b = 8'h3C; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd9);
    check("post_rst_sum", 32'(sum), 32'h02);
    @(negedge clk);
    wait_idle();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
